// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data memory: access-size encodings,
// controller states and the store byte-enable helper.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    // Lanes touched by a store; illegal sizes touch nothing.
    function automatic logic [3:0] store_mask(logic [1:0] size, logic [1:0] lane);
        case (size)
            SZ_BYTE: return 4'b0001 << lane;
            SZ_HALF: return 4'b0011 << lane;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_bytewise_if.sv
// Request/response bundle between the pipeline MEM stage and the data memory.
interface data_mem_bytewise_if;

    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        err;
    logic        busy;

    modport master (
        output rd, wr, size, sign_ext, addr, wdata,
        input  rdata, rvalid, err, busy
    );

    modport slave (
        input  rd, wr, size, sign_ext, addr, wdata,
        output rdata, rvalid, err, busy
    );

endinterface

// File: rtl/load_aligner.sv
// Picks the addressed byte/half/word out of a 32-bit memory word and
// right-justifies it with zero or sign extension.
module load_aligner
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word[8*lane +: 8];
    assign half_sel = lane[1] ? word[31:16] : word[15:0];

    always_comb begin
        case (size)
            SZ_BYTE: result = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SZ_HALF: result = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/data_mem_bytewise.sv
// Byte-addressable data memory with synchronous loads, fault reporting and an
// optional post-reset zero sweep that holds busy high.
module data_mem_bytewise
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS    = 256,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input logic                clk,
    input logic                reset,
    data_mem_bytewise_if.slave bus
);

    localparam int unsigned      PTR_W    = $clog2(DEPTH_WORDS);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH_WORDS - 1);

    logic [31:0]      mem [DEPTH_WORDS];
    state_e           state;
    logic [PTR_W-1:0] clr_ptr;

    logic [1:0]       lane;
    logic             in_range;
    logic             fault;
    logic             req;
    logic             wr_ok;
    logic [PTR_W-1:0] idx;
    logic [3:0]       be;
    logic [31:0]      wword;
    logic [31:0]      rword;
    logic [31:0]      aligned;

    assign lane = bus.addr[1:0];
    // Full 30-bit word index is compared so high addresses never alias.
    assign in_range = {2'b00, bus.addr[31:2]} < DEPTH_WORDS;
    assign idx      = in_range ? bus.addr[PTR_W+1:2] : '0;
    assign req      = bus.rd | bus.wr;
    assign wr_ok    = bus.wr & ~fault;
    assign be       = store_mask(bus.size, lane);
    assign rword    = mem[idx];

    always_comb begin
        fault = ~in_range;
        case (bus.size)
            SZ_HALF:    if (lane[0]) fault = 1'b1;
            SZ_WORD:    if (lane != 2'b00) fault = 1'b1;
            SZ_ILLEGAL: fault = 1'b1;
            default:    ;
        endcase
    end

    always_comb begin
        case (bus.size)
            SZ_BYTE: wword = {4{bus.wdata[7:0]}};
            SZ_HALF: wword = {2{bus.wdata[15:0]}};
            default: wword = bus.wdata;
        endcase
    end

    load_aligner u_load_aligner (
        .word     (rword),
        .lane     (lane),
        .size     (bus.size),
        .sign_ext (bus.sign_ext),
        .result   (aligned)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) begin
                mem[clr_ptr] <= '0;
            end else if (wr_ok) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CLEAR_ON_RESET ? CLEAR : READY;
            clr_ptr    <= '0;
            bus.rdata  <= '0;
            bus.rvalid <= 1'b0;
            bus.err    <= 1'b0;
        end else if (state == CLEAR) begin
            bus.rvalid <= 1'b0;
            bus.err    <= 1'b0;
            clr_ptr    <= clr_ptr + 1'b1;
            if (clr_ptr == LAST_IDX) state <= READY;
        end else begin
            bus.rvalid <= bus.rd;
            bus.err    <= req & fault;
            // Read-before-write: aligned comes from the pre-edge RAM contents.
            if (req && fault) bus.rdata <= '0;
            else if (bus.rd)  bus.rdata <= aligned;
        end
    end

    assign bus.busy = (state == CLEAR);

endmodule

// File: tb/tb_data_mem_bytewise.sv
// Self-checking bench: directed literal checks plus random traffic compared
// every cycle against a byte-array reference model.
module tb_data_mem_bytewise;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    data_mem_bytewise_if bus ();

    data_mem_bytewise #(
        .DEPTH_WORDS    (DEPTH),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: memory as a flat byte array, outputs as expected registers.
    logic [7:0]  mb [DEPTH*4];
    int          clear_left = 0;
    bit          m_live = 1'b0;
    logic [31:0] e_rdata;
    logic        e_rvalid;
    logic        e_err;

    function automatic bit faulty(logic [31:0] a, logic [1:0] s);
        if (s == 2'd3) return 1'b1;
        if ((a % (32'd1 << s)) != 0) return 1'b1;
        return (a / 4) >= DEPTH;
    endfunction

    function automatic logic [31:0] load_val(logic [31:0] a, logic [1:0] s, logic sx);
        int nb = 1 << s;
        logic [31:0] v = '0;
        for (int b = 0; b < nb; b++) v |= 32'(mb[int'(a) + b]) << (8 * b);
        if (sx && nb < 4 && v[8*nb-1]) v |= 32'hFFFF_FFFF << (8 * nb);
        return v;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            clear_left <= DEPTH;
            m_live     <= 1'b1;
            e_rdata    <= '0;
            e_rvalid   <= 1'b0;
            e_err      <= 1'b0;
            for (int i = 0; i < DEPTH * 4; i++) mb[i] <= 8'h00;
        end else if (clear_left != 0) begin
            clear_left <= clear_left - 1;
            e_rvalid   <= 1'b0;
            e_err      <= 1'b0;
        end else begin
            e_rvalid <= bus.rd;
            e_err    <= (bus.rd || bus.wr) && faulty(bus.addr, bus.size);
            if ((bus.rd || bus.wr) && faulty(bus.addr, bus.size)) e_rdata <= '0;
            else if (bus.rd) e_rdata <= load_val(bus.addr, bus.size, bus.sign_ext);
            if (bus.wr && !faulty(bus.addr, bus.size)) begin
                for (int b = 0; b < 4; b++) begin
                    if (b < (1 << bus.size)) mb[int'(bus.addr) + b] <= bus.wdata[8*b +: 8];
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_live) begin
            chk("model.rdata", bus.rdata, e_rdata);
            chk("model.rvalid", 32'(bus.rvalid), 32'(e_rvalid));
            chk("model.err", 32'(bus.err), 32'(e_err));
            chk("model.busy", 32'(bus.busy), 32'(clear_left != 0));
        end
    end

    // One request for one cycle; on return the response is on the outputs.
    task automatic op(input logic r, input logic w, input logic [1:0] s, input logic sx,
                      input logic [31:0] a, input logic [31:0] d);
        bus.rd = r; bus.wr = w; bus.size = s; bus.sign_ext = sx;
        bus.addr = a; bus.wdata = d;
        @(posedge clk);
        #1;
        bus.rd = 1'b0; bus.wr = 1'b0;
    endtask

    task automatic lit(input string nm, input logic [31:0] rdata, input logic rvalid,
                       input logic err);
        chk({nm, ".rdata"}, bus.rdata, rdata);
        chk({nm, ".rvalid"}, 32'(bus.rvalid), 32'(rvalid));
        chk({nm, ".err"}, 32'(bus.err), 32'(err));
    endtask

    task automatic wait_clear(input string nm);
        int n = 0;
        while (bus.busy === 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(nm, n, DEPTH);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        bus.rd = 1'b0; bus.wr = 1'b0; bus.size = 2'b10; bus.sign_ext = 1'b0;
        bus.addr = '0; bus.wdata = '0;
        @(posedge clk);
        #1;
        lit("reset", 32'h0, 1'b0, 1'b0);
        chk("reset.busy", 32'(bus.busy), 32'h1);
        reset = 1'b0;
        wait_clear("busy_cycles");

        op(1, 0, 2'b10, 0, 32'h1C, 0);          lit("lw_1c", 32'h0000_0000, 1, 0);
        op(0, 1, 2'b10, 0, 32'h4, 32'h80FF_7F01); lit("sw_4", 32'h0000_0000, 0, 0);
        op(1, 0, 2'b00, 1, 32'h4, 0);           lit("lb_4", 32'h0000_0001, 1, 0);
        op(1, 0, 2'b00, 1, 32'h5, 0);           lit("lb_5", 32'h0000_007F, 1, 0);
        op(1, 0, 2'b00, 1, 32'h7, 0);           lit("lb_7", 32'hFFFF_FF80, 1, 0);
        op(1, 0, 2'b00, 0, 32'h7, 0);           lit("lbu_7", 32'h0000_0080, 1, 0);
        op(1, 0, 2'b01, 1, 32'h6, 0);           lit("lh_6", 32'hFFFF_80FF, 1, 0);
        op(1, 0, 2'b01, 0, 32'h6, 0);           lit("lhu_6", 32'h0000_80FF, 1, 0);

        op(0, 1, 2'b10, 0, 32'h8, 32'h1122_3344);
        op(0, 1, 2'b00, 0, 32'h9, 32'h0000_00AB);
        op(0, 1, 2'b01, 0, 32'hA, 32'h0000_BEEF);
        op(1, 0, 2'b10, 0, 32'h8, 0);           lit("lw_8", 32'hBEEF_AB44, 1, 0);

        op(0, 1, 2'b10, 0, 32'h2, 32'hDEAD_BEEF); lit("sw_2_fault", 32'h0, 0, 1);
        op(1, 0, 2'b01, 0, 32'h3, 0);           lit("lh_3_fault", 32'h0, 1, 1);
        op(1, 0, 2'b10, 0, 32'h20, 0);          lit("lw_20_fault", 32'h0, 1, 1);
        op(1, 0, 2'b11, 0, 32'h0, 0);           lit("sz11_fault", 32'h0, 1, 1);
        op(1, 0, 2'b10, 0, 32'h0, 0);           lit("lw_0_after", 32'h0, 1, 0);

        op(1, 1, 2'b10, 0, 32'h4, 32'hCAFE_F00D); lit("rw_same", 32'h80FF_7F01, 1, 0);
        op(1, 0, 2'b10, 0, 32'h4, 0);           lit("lw_4_new", 32'hCAFE_F00D, 1, 0);

        // Reset three cycles into the sweep restarts the full count.
        pulse_reset();
        repeat (3) @(posedge clk);
        #1;
        pulse_reset();
        wait_clear("busy_restart");

        // Reset landing during back-to-back reads.
        bus.rd = 1'b1; bus.size = 2'b10; bus.addr = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_mid_reads.rvalid", 32'(bus.rvalid), 32'h0);
        reset = 1'b0;
        bus.rd = 1'b0;
        wait_clear("busy_after_reads");

        for (int i = 0; i < 600; i++) begin
            int r = $urandom_range(0, 199);
            logic [1:0] s = 2'($urandom_range(0, 3));
            logic [31:0] a = $urandom_range(0, 39);
            if ($urandom_range(0, 9) < 7) a = a & ~((32'd1 << s) - 1);
            if (r < 4) a = $urandom;
            reset = (r == 199);
            bus.rd = 1'($urandom_range(0, 1));
            bus.wr = ($urandom_range(0, 2) == 0);
            bus.size = s;
            bus.sign_ext = 1'($urandom_range(0, 1));
            bus.addr = a;
            bus.wdata = $urandom;
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        bus.rd = 1'b0;
        bus.wr = 1'b0;
        repeat (12) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/data_mem_bytewise.md
Name: data_mem_bytewise

Overview:
- Parametrised data memory for the pipeline MEM stage.
- Supports byte, halfword and word loads and stores, with optional sign extension on loads.
- Reads are synchronous: one-cycle latency with a valid strobe.
- Reports misaligned, out-of-range and illegal-size accesses; optionally zero-sweeps the whole array after reset while holding a busy flag that stalls the pipeline.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; any value ≥ 2, power of two not required.
- CLEAR_ON_RESET, 1, 1 = zero every word after reset (busy sweep); 0 = no sweep, contents undefined.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- rd  in  1  read request.
- wr  in  1  write request.
- size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  32  byte address.
- wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- rdata  out  32  registered load result, right-justified and extended.
- rvalid  out  1  one-cycle pulse; rdata is valid this cycle.
- err  out  1  one-cycle pulse for the faulting request.
- busy  out  1  high while clearing; requests are ignored.

Behaviour:
- Reset (posedge, reset=1): rdata=0, rvalid=0, err=0, clr_ptr=0.
  - state=CLEAR and busy=1 if CLEAR_ON_RESET, else state=READY and busy=0.
  - reset dominates all other inputs.
- CLEAR: each posedge with reset=0 writes RAM[clr_ptr]=0 and increments clr_ptr.
  - After writing index DEPTH_WORDS-1: state=READY, busy=0 on that edge.
  - busy is therefore high for exactly DEPTH_WORDS cycles after reset falls.
  - rd/wr are ignored; rvalid=err=0.
  - reset during CLEAR restarts at index 0.
- READY decode:
  - widx = addr[31:2]; lane = addr[1:0], little-endian.
  - fault if any of: widx ≥ DEPTH_WORDS; size=11; size=01 with addr[0]=1; size=10 with addr[1:0]≠0.
- Write (wr=1, no fault): at posedge, update only the addressed lanes.
  - byte: RAM[widx][8*lane+7:8*lane] = wdata[7:0].
  - half: 16 bits at 8*lane = wdata[15:0].
  - word: full 32 bits.
  - Unaddressed lanes are unchanged.
- Read (rd=1, no fault): the next cycle has rvalid=1 and rdata = the addressed lane(s) of RAM[widx], extended per sign_ext. Word loads ignore sign_ext.
- Fault with rd or wr: no RAM update.
  - Next cycle: err=1, rdata=0.
  - rvalid=1 if rd was high (the handshake always completes), else 0.
- rd and wr both high, no fault: both are performed; rdata returns the pre-write contents (read-before-write).
- Back-to-back reads: one per cycle. rvalid stays high continuously; rdata updates every cycle.
- Idle cycle (rd=0): rvalid=0, err=0, rdata holds its last value.
- Widths: size and lane math are 2-bit; the widx range compare is done on the full 30-bit field, so there is no aliasing.

Decomposition:
- Shared package mem_pkg:
  - SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILLEGAL encodings.
  - state enum {CLEAR, READY}.
  - function for the store byte-enable mask from (size, lane).
- Sub-module load_aligner: combinational; word + lane + size + sign_ext → extended 32-bit result. Reused by the future cache.
- Top holds the RAM array, the FSM, clr_ptr, the fault logic and the output registers.

Test Plan:
- DEPTH_WORDS=8, CLEAR_ON_RESET=1: pulse reset for 1 cycle.
  - busy=1 for exactly 8 cycles, then 0.
  - Then lw 0x1C → next cycle rdata=0x00000000, rvalid=1.
- sw 0x80FF7F01 @0x4, then read @0x4:
  - lb → 0x00000001
  - lb @0x5 → 0x0000007F
  - lb signed @0x7 → 0xFFFFFF80
  - lbu @0x7 → 0x00000080
  - lh signed @0x6 → 0xFFFF80FF
  - lhu @0x6 → 0x000080FF
- sw 0x11223344 @0x8; sb 0xAB @0x9; sh 0xBEEF @0xA.
  - lw @0x8 → 0xBEEFAB44.
- Faults: sw @0x2, lh @0x3, lw @0x20, size=11 rd @0x0.
  - Each gives err=1 next cycle and rdata=0; rvalid=1 only for the reads.
  - lw @0x0 afterwards → unchanged value.
- lw @0x4 and sw 0xCAFEF00D @0x4 in the same cycle.
  - rdata=0x80FF7F01; next lw → 0xCAFEF00D.
- Reset at clear cycle 3: busy stays high for a fresh 8 cycles.
  - Reset during back-to-back reads: rvalid=0 the next cycle.
